text_console_writer: RTL and testbench

Consumer end of the character FIFO that the character stager fills: pops ASCII bytes one at a time and renders them into a COLS×ROWS character buffer that the VGA text renderer scans. Maintains the cursor and interprets carriage return, line feed and backspace. Advancing onto a new row clears that row, and the cursor wraps from the last row back to row 0. A full-screen clear runs after reset.

---
 rtl/text_console_writer.sv | 197 +++++++++++++++++++
 tb/tb_text_console_writer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// -----------------------------------------------------------------------------
// text_console_writer
// Drains the character FIFO one byte at a time and renders it into a COLS x ROWS
// character buffer. It tracks the cursor and handles CR, LF and backspace. Moving
// onto a new row clears that row. After the last row the cursor wraps to row 0.
// A full-screen clear runs after every reset.
//
// Optional feature: define CONSOLE_BKSP_EN to make 0x08 a destructive backspace.
// Without it, 0x08 is dropped like any other control byte.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_rst         asynchronous reset, active low
//   i_char_in     FIFO head byte (first-word-fall-through)
//   i_char_avail  FIFO non-empty
//   o_pop         combinational; consumes i_char_in at this rising edge
//   o_wr_en       character-buffer write strobe
//   o_wr_addr     write address, row*COLS+col
//   o_wr_data     byte to store
//   o_cursor_col  current cursor column
//   o_cursor_row  current cursor row
//   o_busy        high while a screen or row clear is in progress
// -----------------------------------------------------------------------------
module text_console_writer #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30,
    parameter int unsigned AW   = $clog2(COLS * ROWS),
    parameter int unsigned CW   = $clog2(COLS),
    parameter int unsigned RW   = $clog2(ROWS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [7:0]    i_char_in,
    input  logic          i_char_avail,
    output logic          o_pop,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_data,
    output logic [CW-1:0] o_cursor_col,
    output logic [RW-1:0] o_cursor_row,
    output logic          o_busy
);

    localparam int unsigned NCELL = COLS * ROWS;
    localparam logic [7:0]  SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        EXEC,
        CLR_ROW
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_held;
    logic [7:0]    w_held;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt;
    logic          r_wr_en;
    logic          w_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [AW-1:0] w_wr_addr;
    logic [7:0]    r_wr_data;
    logic [7:0]    w_wr_data;
    logic [CW-1:0] r_col;
    logic [CW-1:0] w_col;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row;
    logic          r_busy;
    logic          w_adv;
    logic [AW-1:0] w_row_base;
    logic [AW-1:0] w_cur_addr;

    // Start address of the current row and the cursor cell address
    assign w_row_base = AW'(r_row) * AW'(COLS);
    assign w_cur_addr = w_row_base + AW'(r_col);

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= CLR_ALL;
            r_held    <= 8'h00;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= SPACE;
            r_col     <= '0;
            r_row     <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_held    <= w_held;
            r_cnt     <= w_cnt;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_col     <= w_col;
            r_row     <= w_row;
            r_busy    <= (w_state_nxt == CLR_ALL) || (w_state_nxt == CLR_ROW);
        end
    end

    // Next-state, write generation and cursor update
    always_comb begin
        w_state_nxt = r_state;
        w_held      = r_held;
        w_cnt       = r_cnt;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_wr_addr;
        w_wr_data   = r_wr_data;
        w_col       = r_col;
        w_row       = r_row;
        w_adv       = 1'b0;
        o_pop       = 1'b0;

        case (r_state)
            CLR_ALL: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_cnt;
                w_wr_data = SPACE;
                if (r_cnt == AW'(NCELL - 1)) begin
                    w_cnt       = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt = r_cnt + AW'(1);
                end
            end

            IDLE: begin
                o_pop = i_char_avail;
                if (i_char_avail) begin
                    w_held      = i_char_in;
                    w_state_nxt = EXEC;
                end
            end

            EXEC: begin
                w_state_nxt = IDLE;
                if (r_held >= 8'h20 && r_held <= 8'h7E) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_cur_addr;
                    w_wr_data = r_held;
                    if (r_col == CW'(COLS - 1)) begin
                        w_col = '0;
                        w_adv = 1'b1;
                    end else begin
                        w_col = r_col + CW'(1);
                    end
                end else if (r_held == 8'h0D) begin
                    w_col = '0;
                end else if (r_held == 8'h0A) begin
                    w_adv = 1'b1;
`ifdef CONSOLE_BKSP_EN
                end else if (r_held == 8'h08 && r_col != '0) begin
                    // Backspace at column 0 falls through as a no-op
                    w_col     = r_col - CW'(1);
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_cur_addr - AW'(1);
                    w_wr_data = SPACE;
`endif
                end

                if (w_adv) begin
                    w_row       = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
                    w_cnt       = '0;
                    w_state_nxt = CLR_ROW;
                end
            end

            CLR_ROW: begin
                // r_row already holds the new row here
                w_wr_en   = 1'b1;
                w_wr_addr = w_row_base + r_cnt;
                w_wr_data = SPACE;
                if (r_cnt == AW'(COLS - 1)) begin
                    w_cnt       = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt = r_cnt + AW'(1);
                end
            end

            default: begin
                w_state_nxt = CLR_ALL;
            end
        endcase
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_cursor_col = r_col;
    assign o_cursor_row = r_row;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_text_console_writer.sv
// Testbench for text_console_writer.
// The model below is transaction-level. Each consumed byte schedules its expected
// writes, busy window, cursor value and next pop opportunity at absolute cycle
// numbers. One compare task then checks the DUT against that schedule every cycle.
module tb_text_console_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int NCELL = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_in;
    logic        char_avail;
    logic        pop;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    always #5 clk = ~clk;

    text_console_writer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_char_in    (char_in),
        .i_char_avail (char_avail),
        .o_pop        (pop),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_cursor_col (cursor_col),
        .o_cursor_row (cursor_row),
        .o_busy       (busy)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] fifo[$];
    int         cyc;
    int         m_col, m_row, m_pcol, m_prow, m_cur_cyc;
    int         busy_from, busy_to, free_at;
    bit         in_reset;
    int         errors = 0;
    int         checks = 0;

    // Observations used by the literal checks
    int n_wr, n_pop, first_wr_addr, last_wr_addr, last_wr_data, last_wr_cyc, last_pop_cyc, first_wr_cyc;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic push_wr(input int c, input int a, input int d);
        wr_t w;
        w.cyc  = c;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic drive();
        char_avail = (fifo.size() > 0);
        char_in    = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic mark();
        n_wr = 0; n_pop = 0; first_wr_addr = -1; last_wr_addr = -1;
        last_wr_data = -1; last_wr_cyc = -1; last_pop_cyc = -1; first_wr_cyc = -1;
    endtask

    // Release-time schedule: whole screen cleared, then idle at the origin
    task automatic model_release();
        exp_q.delete();
        for (int k = 0; k < NCELL; k++) push_wr(1 + k, k, 8'h20);
        busy_from = 0; busy_to = NCELL - 1; free_at = NCELL;
        m_col = 0; m_row = 0; m_pcol = 0; m_prow = 0; m_cur_cyc = 0;
    endtask

    // Byte b executes in cycle e: its effects become visible from e+1 onward
    task automatic model_byte(input logic [7:0] b, input int e);
        int ncol = m_col;
        int nrow = m_row;
        bit adv  = 1'b0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(e + 1, m_row * COLS + m_col, int'(b));
            if (m_col == COLS - 1) begin ncol = 0; adv = 1'b1; end
            else ncol = m_col + 1;
        end else if (b == 8'h0D) begin
            ncol = 0;
        end else if (b == 8'h0A) begin
            adv = 1'b1;
`ifdef CONSOLE_BKSP_EN
        end else if (b == 8'h08 && m_col > 0) begin
            ncol = m_col - 1;
            push_wr(e + 1, m_row * COLS + ncol, 8'h20);
`endif
        end
        if (adv) begin
            nrow = (m_row + 1) % ROWS;
            for (int k = 0; k < COLS; k++) push_wr(e + 2 + k, nrow * COLS + k, 8'h20);
            busy_from = e + 1; busy_to = e + COLS; free_at = e + COLS + 1;
        end else begin
            free_at = e + 1;
        end
        m_pcol = m_col; m_prow = m_row;
        m_col = ncol;   m_row = nrow;
        m_cur_cyc = e + 1;
    endtask

    // One clock: compare at negedge, then advance and feed the model
    task automatic tick();
        bit   exp_wr;
        bit   popped;
        wr_t  w;
        @(negedge clk);
        popped = 1'b0;
        if (in_reset) begin
            chk("rst_pop", int'(pop), 0);
            chk("rst_wr_en", int'(wr_en), 0);
            chk("rst_wr_addr", int'(wr_addr), 0);
            chk("rst_wr_data", int'(wr_data), 8'h20);
            chk("rst_col", int'(cursor_col), 0);
            chk("rst_row", int'(cursor_row), 0);
            chk("rst_busy", int'(busy), 1);
        end else begin
            chk("pop", int'(pop), int'((fifo.size() > 0) && (cyc >= free_at)));
            exp_wr = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("wr_en", int'(wr_en), int'(exp_wr));
            if (exp_wr) begin
                w = exp_q.pop_front();
                if (wr_en) begin
                    chk("wr_addr", int'(wr_addr), w.addr);
                    chk("wr_data", int'(wr_data), w.data);
                end
            end
            chk("busy", int'(busy), int'(cyc >= busy_from && cyc <= busy_to));
            chk("cursor_col", int'(cursor_col), (cyc >= m_cur_cyc) ? m_col : m_pcol);
            chk("cursor_row", int'(cursor_row), (cyc >= m_cur_cyc) ? m_row : m_prow);
            popped = pop && (fifo.size() > 0);
        end
        if (wr_en) begin
            n_wr++;
            if (first_wr_addr < 0) begin first_wr_addr = int'(wr_addr); first_wr_cyc = cyc; end
            last_wr_addr = int'(wr_addr); last_wr_data = int'(wr_data); last_wr_cyc = cyc;
        end
        if (popped) begin n_pop++; last_pop_cyc = cyc; end
        @(posedge clk);
        #1;
        cyc++;
        if (popped) model_byte(fifo.pop_front(), cyc);
        drive();
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || fifo.size() > 0 || cyc < free_at) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("idle_timeout", n, -1);
        tick();
        tick();
    endtask

    task automatic put(input logic [7:0] b);
        fifo.push_back(b);
        drive();
    endtask

    task automatic release_rst();
        rst = 1'b1;
        in_reset = 1'b0;
        cyc = 0;
        model_release();
    endtask

    initial begin
        rst = 1'b0; in_reset = 1'b1; cyc = 0;
        m_col = 0; m_row = 0; m_pcol = 0; m_prow = 0; m_cur_cyc = 0;
        busy_from = 0; busy_to = 0; free_at = 0;
        drive();
        mark();
        repeat (3) tick();

        // Power-up clear
        release_rst();
        mark();
        run_idle(3000);
        chk("clrall_count", n_wr, 2400);
        chk("clrall_first_addr", first_wr_addr, 0);
        chk("clrall_first_cyc", first_wr_cyc, 1);
        chk("clrall_last_addr", last_wr_addr, 2399);
        chk("clrall_busy_after", int'(busy), 0);

        // Single printable character: two-cycle latency
        mark();
        put(8'h41);
        run_idle(100);
        chk("A_latency", last_wr_cyc - last_pop_cyc, 2);
        chk("A_addr", last_wr_addr, 0);
        chk("A_data", last_wr_data, 8'h41);
        chk("A_col", int'(cursor_col), 1);

        // CR then LF from column 5
        put(8'h62); put(8'h63); put(8'h64); put(8'h65);
        run_idle(100);
        chk("col5", int'(cursor_col), 5);
        mark();
        put(8'h0D); put(8'h0A);
        run_idle(200);
        chk("crlf_writes", n_wr, 80);
        chk("crlf_first", first_wr_addr, 80);
        chk("crlf_last", last_wr_addr, 159);
        chk("crlf_col", int'(cursor_col), 0);
        chk("crlf_row", int'(cursor_row), 1);

        // Discarded control bytes, then 79 printables and a column wrap
        put(8'h7F); put(8'h00); put(8'h1B); put(8'h80); put(8'hFF); put(8'h09); put(8'h07);
        for (int i = 0; i < 79; i++) put(8'(8'h21 + (i % 94)));
        run_idle(500);
        chk("pre_wrap_col", int'(cursor_col), 79);
        mark();
        put(8'h5A);
        run_idle(200);
        chk("wrap_writes", n_wr, 81);
        chk("wrap_char_addr", first_wr_addr, 159);
        chk("wrap_last_clr", last_wr_addr, 239);
        chk("wrap_col", int'(cursor_col), 0);
        chk("wrap_row", int'(cursor_row), 2);

        // Row wrap from row 29 back to row 0
        for (int i = 0; i < 27; i++) put(8'h0A);
        run_idle(5000);
        chk("row29", int'(cursor_row), 29);
        mark();
        put(8'h0A);
        run_idle(200);
        chk("rowwrap_row", int'(cursor_row), 0);
        chk("rowwrap_writes", n_wr, 80);
        chk("rowwrap_first", first_wr_addr, 0);
        chk("rowwrap_last", last_wr_addr, 79);

        // Backspace at col 3 row 2, then at col 0
        put(8'h0A); put(8'h0A); put(8'h78); put(8'h79); put(8'h7A);
        run_idle(500);
        mark();
        put(8'h08);
        run_idle(50);
`ifdef CONSOLE_BKSP_EN
        chk("bs_writes", n_wr, 1);
        chk("bs_addr", last_wr_addr, 162);
        chk("bs_data", last_wr_data, 8'h20);
        chk("bs_col", int'(cursor_col), 2);
`else
        chk("bs_writes", n_wr, 0);
        chk("bs_col", int'(cursor_col), 3);
`endif
        put(8'h0D);
        run_idle(50);
        mark();
        put(8'h08);
        run_idle(50);
        chk("bs0_pops", n_pop, 1);
        chk("bs0_writes", n_wr, 0);
        chk("bs0_col", int'(cursor_col), 0);
        chk("bs0_row", int'(cursor_row), 2);

        // Reset in the middle of a row clear
        put(8'h0A);
        repeat (20) tick();
        chk("midclr_busy", int'(busy), 1);
        rst = 1'b0;
        in_reset = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        release_rst();
        mark();
        run_idle(3000);
        chk("reclr_count", n_wr, 2400);
        chk("reclr_first", first_wr_addr, 0);
        chk("reclr_last", last_wr_addr, 2399);
        mark();
        put(8'h07);
        run_idle(50);
        chk("bel_pops", n_pop, 1);
        chk("bel_writes", n_wr, 0);
        chk("bel_col", int'(cursor_col), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
